// File: rtl/conv_pkg.sv
// Shared types and constants for the BRAM port arbiter.
// Contents: requester id width, arbiter FSM states, read-return tag,
// memory command payload and the rotating-pointer increment helper.
package conv_pkg;

  localparam int unsigned MAX_NREQ = 4;
  localparam int unsigned REQ_ID_W = 2;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;

  localparam logic [BE_W-1:0] BYTE_EN_ALL = 4'b1111;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  // Travels alongside an accepted read until its data comes back.
  typedef struct packed {
    logic                vld;
    logic [REQ_ID_W-1:0] id;
  } rd_tag_t;

  // Access selected from the granted requester.
  typedef struct packed {
    logic              rd;
    logic [BE_W-1:0]   we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Requester after id, wrapping at nreq.
  function automatic logic [REQ_ID_W-1:0] next_id(input logic [REQ_ID_W-1:0] id,
                                                  input int unsigned         nreq);
    if ((32'(id) + 32'd1) >= nreq) begin
      return '0;
    end
    return id + REQ_ID_W'(1);
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotating priority encoder: first active requester at or after ptr.
// Ports:
//   active  in  NREQ      requesters with a pending access
//   ptr     in  REQ_ID_W  highest-priority requester this cycle
//   gnt_oh  out NREQ      one-hot pick, zero when nothing active
//   gnt_id  out REQ_ID_W  index of the pick
module arb_rr_pick
  import conv_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]     active,
  input  logic [REQ_ID_W-1:0] ptr,
  output logic [NREQ-1:0]     gnt_oh,
  output logic [REQ_ID_W-1:0] gnt_id
);

  logic found;

  // Outer loop walks priority order starting at ptr; first hit wins.
  always_comb begin
    gnt_oh = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned n = 0; n < NREQ; n++) begin
        if (!found && active[n] && (((32'(ptr) + k) % NREQ) == n)) begin
          gnt_oh[n] = 1'b1;
          gnt_id    = REQ_ID_W'(n);
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one word-addressed BRAM port between NREQ requesters with
// round-robin grant, optional burst lock capped at MAX_HOLD accepts while
// others wait, a registered memory command and tag-routed read return.
// Optional feature macro: ARB_PERF_CNT_EN (adds perf_clr, perf_gnt, perf_wait).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rq_rd/we/addr/wdata per-requester access (slices 1/4/32/32 bits each)
//   rq_lock             keep the grant after this access
//   rq_gnt              one-hot grant, combinational
//   rq_rvalid/rq_rdata  registered read return, one-hot valid
//   M_R_req/M_addr/M_W_req/M_W_data  registered BRAM command
//   M_R_data            BRAM read data
//   perf_clr/perf_gnt/perf_wait      accept and wait counters (optional)
module bram_port_arbiter
  import conv_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        rq_rd,
  input  logic [BE_W*NREQ-1:0]   rq_we,
  input  logic [ADDR_W*NREQ-1:0] rq_addr,
  input  logic [DATA_W*NREQ-1:0] rq_wdata,
  input  logic [NREQ-1:0]        rq_lock,
  output logic [NREQ-1:0]        rq_gnt,
  output logic [NREQ-1:0]        rq_rvalid,
  output logic [DATA_W-1:0]      rq_rdata,
  output logic                   M_R_req,
  output logic [ADDR_W-1:0]      M_addr,
  output logic [BE_W-1:0]        M_W_req,
  output logic [DATA_W-1:0]      M_W_data,
  input  logic [DATA_W-1:0]      M_R_data
`ifdef ARB_PERF_CNT_EN
  ,
  input  logic                   perf_clr,
  output logic [32*NREQ-1:0]     perf_gnt,
  output logic [32*NREQ-1:0]     perf_wait
`endif
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_t          state_q, state_d;
  logic [REQ_ID_W-1:0] owner_q, owner_d;
  logic [REQ_ID_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [NREQ-1:0]     active;
  logic [NREQ-1:0]     owner_oh;
  logic                owner_act;
  logic                force_rel;
  logic                owner_keep;
  logic [NREQ-1:0]     pick_oh;
  logic [REQ_ID_W-1:0] pick_id;
  logic [NREQ-1:0]     gnt;
  logic [REQ_ID_W-1:0] acc_id;
  logic                accept;
  mem_cmd_t            sel_cmd;
  rd_tag_t             tag_in;
  rd_tag_t             tag_q [RD_LAT+1];

  // Request activity and owner decode.
  always_comb begin
    active   = '0;
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      active[i]   = rq_rd[i] | (|rq_we[BE_W*i +: BE_W]);
      owner_oh[i] = (owner_q == REQ_ID_W'(i));
    end
  end

  assign owner_act = |(owner_oh & active);
  // Owner loses the lock once it has used its budget and someone else waits.
  assign force_rel = (state_q == ARB_OWNED) && (hold_q == HOLD_W'(MAX_HOLD)) &&
                     (|(active & ~owner_oh));

  arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .active (active),
    .ptr    (ptr_q),
    .gnt_oh (pick_oh),
    .gnt_id (pick_id)
  );

  // Arbiter FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Arbiter FSM next state and grant. A released owner falls straight through
  // to the round-robin pick in the same cycle, so ownership changes cost no bubble.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    gnt        = '0;
    acc_id     = '0;
    accept     = 1'b0;
    owner_keep = 1'b0;
    if (rst) begin
      owner_keep = (state_q == ARB_OWNED) && owner_act && !force_rel;
      if (owner_keep) begin
        gnt    = owner_oh;
        acc_id = owner_q;
      end else begin
        gnt    = pick_oh;
        acc_id = pick_id;
      end
      // Grants only ever go to active requesters, so any grant is an accept.
      accept = |gnt;
      if (accept) begin
        ptr_d = next_id(acc_id, NREQ);
        if (|(gnt & rq_lock)) begin
          state_d = ARB_OWNED;
          owner_d = acc_id;
          if (!owner_keep) begin
            hold_d = HOLD_W'(1);
          end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end else begin
          state_d = ARB_IDLE;
          hold_d  = '0;
        end
      end else begin
        state_d = ARB_IDLE;
        hold_d  = '0;
      end
    end
  end

  assign rq_gnt = gnt;

  // Mux the granted requester's access.
  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_cmd.rd    = rq_rd[i];
        sel_cmd.we    = rq_we[BE_W*i +: BE_W];
        sel_cmd.addr  = rq_addr[ADDR_W*i +: ADDR_W];
        sel_cmd.wdata = rq_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // Registered BRAM command; address and data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      M_R_req  <= 1'b0;
      M_W_req  <= '0;
      M_addr   <= '0;
      M_W_data <= '0;
    end else begin
      M_R_req <= accept & sel_cmd.rd;
      M_W_req <= accept ? sel_cmd.we : '0;
      if (accept) begin
        M_addr   <= sel_cmd.addr;
        M_W_data <= sel_cmd.wdata;
      end
    end
  end

  assign tag_in.vld = accept & sel_cmd.rd;
  assign tag_in.id  = acc_id;

  // Read tag pipe: last stage lines up with M_R_data being valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s <= RD_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned s = 1; s <= RD_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // Read return, routed by tag id.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rq_rvalid <= '0;
      rq_rdata  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        rq_rvalid[i] <= tag_q[RD_LAT].vld && (tag_q[RD_LAT].id == REQ_ID_W'(i));
      end
      if (tag_q[RD_LAT].vld) begin
        rq_rdata <= M_R_data;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Saturating per-requester accept and wait counters; clear beats increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_gnt  <= '0;
      perf_wait <= '0;
    end else if (perf_clr) begin
      perf_gnt  <= '0;
      perf_wait <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && (perf_gnt[32*i +: 32] != 32'hFFFF_FFFF)) begin
          perf_gnt[32*i +: 32] <= perf_gnt[32*i +: 32] + 32'd1;
        end
        if (active[i] && !gnt[i] && (perf_wait[32*i +: 32] != 32'hFFFF_FFFF)) begin
          perf_wait[32*i +: 32] <= perf_wait[32*i +: 32] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: a vector table for the
// cycle-by-cycle arbitration and read return, then hand-written sequences for
// locked bursts, the hold cap, read-during-write, perf counters and reset
// in the middle of reads (second instance with RD_LAT=3).
module tb_bram_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  rq_rd;
  logic [7:0]  rq_we;
  logic [63:0] rq_addr;
  logic [63:0] rq_wdata;
  logic [1:0]  rq_lock;

  logic [1:0]  rq_gnt, rq_rvalid;
  logic [31:0] rq_rdata;
  logic        M_R_req;
  logic [31:0] M_addr, M_W_data, bram_q;
  logic [3:0]  M_W_req;

  logic [1:0]  gnt3, rv3;
  logic [31:0] rdata3, maddr3, mwd3;
  logic        mrd3;
  logic [3:0]  mwe3;
  logic [31:0] bram3;
  assign bram3 = 32'h3333_0000;

`ifdef ARB_PERF_CNT_EN
  logic        perf_clr;
  logic [63:0] perf_gnt, perf_wait, perf_gnt3, perf_wait3;
`endif

  bram_port_arbiter #(.NREQ(2), .RD_LAT(1), .MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .rq_rd(rq_rd), .rq_we(rq_we), .rq_addr(rq_addr),
    .rq_wdata(rq_wdata), .rq_lock(rq_lock), .rq_gnt(rq_gnt), .rq_rvalid(rq_rvalid),
    .rq_rdata(rq_rdata), .M_R_req(M_R_req), .M_addr(M_addr), .M_W_req(M_W_req),
    .M_W_data(M_W_data), .M_R_data(bram_q)
`ifdef ARB_PERF_CNT_EN
    , .perf_clr(perf_clr), .perf_gnt(perf_gnt), .perf_wait(perf_wait)
`endif
  );

  bram_port_arbiter #(.NREQ(2), .RD_LAT(3), .MAX_HOLD(16)) dut3 (
    .clk(clk), .rst(rst), .rq_rd(rq_rd), .rq_we(rq_we), .rq_addr(rq_addr),
    .rq_wdata(rq_wdata), .rq_lock(rq_lock), .rq_gnt(gnt3), .rq_rvalid(rv3),
    .rq_rdata(rdata3), .M_R_req(mrd3), .M_addr(maddr3), .M_W_req(mwe3),
    .M_W_data(mwd3), .M_R_data(bram3)
`ifdef ARB_PERF_CNT_EN
    , .perf_clr(perf_clr), .perf_gnt(perf_gnt3), .perf_wait(perf_wait3)
`endif
  );

  // BRAM model, latency 1, read returns the word before a same-edge write.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h1000_0000 + 32'(k);
      bram_q <= '0;
    end else begin
      if (M_R_req) bram_q <= mem[M_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (M_W_req[b]) mem[M_addr[9:2]][8*b +: 8] <= M_W_data[8*b +: 8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] rd, input logic [3:0] we0, input logic [3:0] we1,
                       input logic [1:0] lock, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] wd0, input logic [31:0] wd1);
    rq_rd    = rd;
    rq_we    = {we1, we0};
    rq_lock  = lock;
    rq_addr  = {a1, a0};
    rq_wdata = {wd1, wd0};
  endtask

  task automatic idle(input int n);
    drive(2'b00, 4'h0, 4'h0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  typedef struct {
    logic [1:0]  rd;
    logic [3:0]  we0;
    logic [1:0]  lock;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] wd0;
    logic [1:0]  gnt;
    logic        mrd;
    logic [3:0]  mwe;
    logic [31:0] maddr;
    logic [1:0]  rv;
    logic [31:0] rdat;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  initial begin
    //           rd     we0   lock   a0      a1      wd0           gnt    mrd  mwe   maddr   rv     rdat
    vecs[0]  = '{2'b11, 4'h0, 2'b00, 32'h00, 32'h10, 32'h0,        2'b01, 1'b1, 4'h0, 32'h00, 2'b00, 32'h0};
    vecs[1]  = '{2'b11, 4'h0, 2'b00, 32'h04, 32'h14, 32'h0,        2'b10, 1'b1, 4'h0, 32'h14, 2'b00, 32'h0};
    vecs[2]  = '{2'b11, 4'h0, 2'b00, 32'h08, 32'h18, 32'h0,        2'b01, 1'b1, 4'h0, 32'h08, 2'b01, 32'h1000_0000};
    vecs[3]  = '{2'b11, 4'h0, 2'b00, 32'h0C, 32'h1C, 32'h0,        2'b10, 1'b1, 4'h0, 32'h1C, 2'b10, 32'h1000_0005};
    vecs[4]  = '{2'b00, 4'h0, 2'b00, 32'h00, 32'h00, 32'h0,        2'b00, 1'b0, 4'h0, 32'h1C, 2'b01, 32'h1000_0002};
    vecs[5]  = '{2'b00, 4'h3, 2'b00, 32'h20, 32'h00, 32'h1234_5678, 2'b01, 1'b0, 4'h3, 32'h20, 2'b10, 32'h1000_0007};
    vecs[6]  = '{2'b10, 4'h0, 2'b00, 32'h00, 32'h20, 32'h0,        2'b10, 1'b1, 4'h0, 32'h20, 2'b00, 32'h0};
    vecs[7]  = '{2'b01, 4'h0, 2'b00, 32'h24, 32'h00, 32'h0,        2'b01, 1'b1, 4'h0, 32'h24, 2'b00, 32'h0};
    vecs[8]  = '{2'b00, 4'h0, 2'b00, 32'h00, 32'h00, 32'h0,        2'b00, 1'b0, 4'h0, 32'h24, 2'b10, 32'h1000_5678};
    vecs[9]  = '{2'b00, 4'h0, 2'b00, 32'h00, 32'h00, 32'h0,        2'b00, 1'b0, 4'h0, 32'h24, 2'b01, 32'h1000_0009};
    vecs[10] = '{2'b01, 4'h0, 2'b00, 32'h30, 32'h00, 32'h0,        2'b01, 1'b1, 4'h0, 32'h30, 2'b00, 32'h0};
    vecs[11] = '{2'b00, 4'h0, 2'b00, 32'h00, 32'h00, 32'h0,        2'b00, 1'b0, 4'h0, 32'h30, 2'b00, 32'h0};
    vecs[12] = '{2'b00, 4'h0, 2'b00, 32'h00, 32'h00, 32'h0,        2'b00, 1'b0, 4'h0, 32'h30, 2'b01, 32'h1000_000C};
    vecs[13] = '{2'b11, 4'h0, 2'b10, 32'h00, 32'h34, 32'h0,        2'b10, 1'b1, 4'h0, 32'h34, 2'b00, 32'h0};
    vecs[14] = '{2'b11, 4'h0, 2'b10, 32'h00, 32'h38, 32'h0,        2'b10, 1'b1, 4'h0, 32'h38, 2'b00, 32'h0};
    vecs[15] = '{2'b11, 4'h0, 2'b00, 32'h00, 32'h3C, 32'h0,        2'b10, 1'b1, 4'h0, 32'h3C, 2'b10, 32'h1000_000D};
    vecs[16] = '{2'b11, 4'h0, 2'b00, 32'h44, 32'h00, 32'h0,        2'b01, 1'b1, 4'h0, 32'h44, 2'b10, 32'h1000_000E};
    vecs[17] = '{2'b10, 4'h0, 2'b10, 32'h00, 32'h48, 32'h0,        2'b10, 1'b1, 4'h0, 32'h48, 2'b10, 32'h1000_000F};
    vecs[18] = '{2'b01, 4'h0, 2'b00, 32'h4C, 32'h00, 32'h0,        2'b01, 1'b1, 4'h0, 32'h4C, 2'b01, 32'h1000_0011};
    vecs[19] = '{2'b00, 4'h0, 2'b00, 32'h00, 32'h00, 32'h0,        2'b00, 1'b0, 4'h0, 32'h4C, 2'b10, 32'h1000_0012};
    vecs[20] = '{2'b00, 4'h0, 2'b00, 32'h00, 32'h00, 32'h0,        2'b00, 1'b0, 4'h0, 32'h4C, 2'b01, 32'h1000_0013};

    rst = 1'b0;
`ifdef ARB_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    drive(2'b11, 4'h0, 4'h0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("rst.gnt", 32'(rq_gnt), 32'h0);
    idle(3);
    chk("rst.mrd", 32'(M_R_req), 32'h0);
    chk("rst.mwe", 32'(M_W_req), 32'h0);
    chk("rst.maddr", M_addr, 32'h0);
    chk("rst.mwdata", M_W_data, 32'h0);
    chk("rst.rvalid", 32'(rq_rvalid), 32'h0);
    chk("rst.rdata", rq_rdata, 32'h0);
    rst = 1'b1;

    // Vector table.
    for (int r = 0; r < NV; r++) begin
      drive(vecs[r].rd, vecs[r].we0, 4'h0, vecs[r].lock, vecs[r].a0, vecs[r].a1, vecs[r].wd0, 32'h0);
      #2;
      chk($sformatf("v%0d.gnt", r), 32'(rq_gnt), 32'(vecs[r].gnt));
      cyc();
      chk($sformatf("v%0d.mrd", r), 32'(M_R_req), 32'(vecs[r].mrd));
      chk($sformatf("v%0d.mwe", r), 32'(M_W_req), 32'(vecs[r].mwe));
      chk($sformatf("v%0d.maddr", r), M_addr, vecs[r].maddr);
      chk($sformatf("v%0d.rvalid", r), 32'(rq_rvalid), 32'(vecs[r].rv));
      if (vecs[r].rv != 2'b00) chk($sformatf("v%0d.rdata", r), rq_rdata, vecs[r].rdat);
    end

    // Locked burst of 40 reads by requester 0.
    for (int k = 0; k < 40; k++) begin
      drive(2'b01, 4'h0, 4'h0, 2'b01, 32'(4 * k), 32'h0, 32'h0, 32'h0);
      #2;
      chk($sformatf("burst%0d.gnt", k), 32'(rq_gnt), 32'h1);
      cyc();
      chk($sformatf("burst%0d.maddr", k), M_addr, 32'(4 * k));
    end
    idle(1);

    // Hold cap: requester 1 waits from cycle 3, gets in after 16 owner accepts.
    for (int c = 0; c < 18; c++) begin
      drive({(c >= 3 && c <= 16) ? 1'b1 : 1'b0, 1'b1}, 4'h0, 4'h0, 2'b01,
            32'h80, 32'h90, 32'h0, 32'h0);
      #2;
      chk($sformatf("hold%0d.gnt", c), 32'(rq_gnt), (c == 16) ? 32'h2 : 32'h1);
      cyc();
    end
    idle(4);

    // Read and write together from requester 1.
    drive(2'b10, 4'h0, 4'hF, 2'b00, 32'h0, 32'h40, 32'h0, 32'hDEAD_BEEF);
    #2;
    chk("rdw.gnt", 32'(rq_gnt), 32'h2);
    cyc();
    chk("rdw.mrd", 32'(M_R_req), 32'h1);
    chk("rdw.mwe", 32'(M_W_req), 32'hF);
    chk("rdw.maddr", M_addr, 32'h40);
    chk("rdw.mwdata", M_W_data, 32'hDEAD_BEEF);
    drive(2'b00, 4'h0, 4'h0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk($sformatf("rdw.rv%0d", k), 32'(rq_rvalid), (k == 2) ? 32'h2 : 32'h0);
      chk($sformatf("rdw.rv3_%0d", k), 32'(rv3), (k == 4) ? 32'h2 : 32'h0);
      if (k == 2) chk("rdw.old", rq_rdata, 32'h1000_0010);
      if (k == 4) chk("rdw.rdata3", rdata3, 32'h3333_0000);
    end
    drive(2'b01, 4'h0, 4'h0, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0);
    cyc();
    idle(2);
    chk("rdw.new.rv", 32'(rq_rvalid), 32'h1);
    chk("rdw.new", rq_rdata, 32'hDEAD_BEEF);
    idle(4);

`ifdef ARB_PERF_CNT_EN
    perf_clr = 1'b1;
    cyc();
    perf_clr = 1'b0;
    drive(2'b11, 4'h0, 4'h0, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0);
    for (int k = 0; k < 10; k++) cyc();
    idle(1);
    chk("perf.gnt0", perf_gnt[31:0], 32'd5);
    chk("perf.gnt1", perf_gnt[63:32], 32'd5);
    chk("perf.wait0", perf_wait[31:0], 32'd5);
    chk("perf.wait1", perf_wait[63:32], 32'd5);
    drive(2'b11, 4'h0, 4'h0, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0);
    perf_clr = 1'b1;
    cyc();
    perf_clr = 1'b0;
    idle(1);
    chk("perf.clr.gnt", perf_gnt[31:0] | perf_gnt[63:32], 32'd0);
    chk("perf.clr.wait", perf_wait[31:0] | perf_wait[63:32], 32'd0);
    idle(4);
`endif

    // Reset during reads on the RD_LAT=3 instance.
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, 4'h0, 4'h0, 2'b00, 32'(32'h100 + 4 * k), 32'h0, 32'h0, 32'h0);
      cyc();
    end
    drive(2'b01, 4'h0, 4'h0, 2'b00, 32'h10C, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    chk("mrst.mrd3", 32'(mrd3), 32'h0);
    chk("mrst.mwe3", 32'(mwe3), 32'h0);
    chk("mrst.maddr3", maddr3, 32'h0);
    chk("mrst.mwd3", mwd3, 32'h0);
    chk("mrst.gnt3", 32'(gnt3), 32'h0);
    chk("mrst.rv3", 32'(rv3), 32'h0);
    chk("mrst.rdata3", rdata3, 32'h0);
    chk("mrst.gnt", 32'(rq_gnt), 32'h0);
    chk("mrst.maddr", M_addr, 32'h0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk($sformatf("mrst.hold%0d.rv3", k), 32'(rv3), 32'h0);
      chk($sformatf("mrst.hold%0d.gnt3", k), 32'(gnt3), 32'h0);
    end
    drive(2'b00, 4'h0, 4'h0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk($sformatf("mrst.after%0d.rv3", k), 32'(rv3), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
